// File: rtl/bus_slave_pkg.sv
// bus_slave_pkg: shared FSM state type and counter sizing for the serial bus slave.
package bus_slave_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WAIT, FETCH, RDATA} state_t;
  localparam int WAIT_W = 4;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_slave_ram.sv
// bus_slave_ram: single-port RAM, synchronous write and read-first synchronous read.
module bus_slave_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/bus_slave_mem.sv
// bus_slave_mem: serial bus slave with burst auto-increment and programmable read latency.
module bus_slave_mem
  import bus_slave_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int BURST_W  = 4,
  parameter int READ_LAT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic read_en,
  input  logic write_en,
  input  logic master_valid,
  input  logic master_ready,
  input  logic rx_addr,
  input  logic rx_data,
  input  logic rx_burst,
  output logic slave_valid,
  output logic slave_ready,
  output logic tx_data,
  output logic rx_done,
  output logic tx_done
);
  localparam int AC_W = cnt_w(ADDR_W);
  localparam int DC_W = cnt_w(DATA_W);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [BURST_W-1:0] burst, beat;
  logic [AC_W-1:0] acnt;
  logic [DC_W-1:0] bcnt;
  logic [WAIT_W-1:0] wcnt;
  logic [DATA_W-1:0] wsh, din, dout;
  logic is_write, mem_we, acc, start, addr_last, word_last, beat_last;
  assign slave_ready = state inside {IDLE, ADDR, WDATA};
  assign slave_valid = state == RDATA;
  assign tx_data = slave_valid & dout[bcnt];
  assign acc = master_valid & slave_ready;
  assign start = (state == IDLE) && acc && (read_en ^ write_en);
  assign addr_last = acnt == AC_W'(ADDR_W - 1);
  assign word_last = bcnt == DC_W'(DATA_W - 1);
  assign beat_last = beat == burst;
  assign din = {rx_data, wsh[DATA_W-1:1]};
  always_comb begin
    state_n = state;
    mem_we = 1'b0;
    case (state)
      IDLE:  state_n = start ? ADDR : IDLE;
      ADDR:  if (acc && addr_last) state_n = is_write ? WDATA : (READ_LAT > 0 ? WAIT : FETCH);
      WDATA: begin
        mem_we = acc && word_last;
        if (mem_we && beat_last) state_n = IDLE;
      end
      WAIT:  state_n = (wcnt == WAIT_W'(READ_LAT - 1)) ? FETCH : WAIT;
      FETCH: state_n = RDATA;
      RDATA: if (master_ready && word_last) state_n = beat_last ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // The first accepted bit (in IDLE) already carries address and burst bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      burst <= '0;
      beat <= '0;
      acnt <= '0;
      bcnt <= '0;
      wcnt <= '0;
      wsh <= '0;
      is_write <= 1'b0;
      rx_done <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      rx_done <= mem_we && beat_last;
      tx_done <= (state == RDATA) && master_ready && word_last && beat_last;
      case (state)
        IDLE: if (start) begin
          is_write <= write_en;
          addr <= {rx_addr, addr[ADDR_W-1:1]};
          burst <= {rx_burst, burst[BURST_W-1:1]};
          acnt <= AC_W'(1);
          beat <= '0;
          bcnt <= '0;
          wcnt <= '0;
        end
        ADDR: if (acc) begin
          addr <= {rx_addr, addr[ADDR_W-1:1]};
          if (int'(acnt) < BURST_W) burst <= {rx_burst, burst[BURST_W-1:1]};
          acnt <= addr_last ? '0 : acnt + 1'b1;
        end
        WDATA: if (acc) begin
          wsh <= din;
          bcnt <= word_last ? '0 : bcnt + 1'b1;
          if (word_last) begin
            addr <= addr + 1'b1;
            beat <= beat + 1'b1;
          end
        end
        WAIT: wcnt <= wcnt + 1'b1;
        RDATA: if (master_ready) begin
          bcnt <= word_last ? '0 : bcnt + 1'b1;
          if (word_last) begin
            addr <= addr + 1'b1;
            beat <= beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  bus_slave_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .we(mem_we),
    .addr(addr),
    .din(din),
    .dout(dout)
  );
endmodule

// File: doc/bus_slave_mem.md
# bus_slave_mem

Parametrised serial system-bus slave with an internal single-port memory. It is the next generation of the fixed 12-bit-address / 8-bit-data BRAM slave. Address, data and burst widths are set by parameters, bursts auto-increment, and read latency is programmable. Each instance sits on the serial bus behind the arbiter as one addressable slave, driven by the same master handshake signals.

## Interface
- ADDR_W, 12, address bits; memory depth is 2**ADDR_W words
- DATA_W, 8, word width in bits
- BURST_W, 4, burst-length field width (BURST_W <= ADDR_W); beats = field + 1
- READ_LAT, 0, extra wait cycles before the first read beat (0..15)
- clk  in  1  bus clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; returns FSM to IDLE
- read_en  in  1  read request, sampled at transaction start
- write_en  in  1  write request, sampled at transaction start
- master_valid  in  1  master is presenting a valid bit on rx_addr/rx_data/rx_burst
- master_ready  in  1  master accepts the bit on tx_data this cycle
- rx_addr  in  1  serial address, LSB first
- rx_data  in  1  serial write data, LSB first
- rx_burst  in  1  serial burst field, LSB first, in parallel with the low address bits
- slave_valid  out  1  tx_data holds a valid read bit
- slave_ready  out  1  slave accepts serial input bits this cycle
- tx_data  out  1  serial read data, LSB first
- rx_done  out  1  one-cycle pulse after the last write beat is stored
- tx_done  out  1  one-cycle pulse after the last read bit is accepted

## Operation
- States: IDLE, ADDR, WDATA, WAIT, FETCH, RDATA.
- A bit is accepted on any cycle with master_valid & slave_ready. slave_ready = 1 in IDLE, ADDR and WDATA. It is 0 elsewhere.
- IDLE: a transaction starts on an accepted bit with read_en ^ write_en = 1. That cycle supplies address bit 0 and burst bit 0, and the FSM goes to ADDR. If both or neither enable is high, the bit is ignored and the FSM stays in IDLE.
- ADDR: shifts one address bit per accepted bit. Burst bits are taken from the first BURST_W accepted bits. After ADDR_W bits:
  - write goes to WDATA
  - read goes to WAIT if READ_LAT > 0, else FETCH
- WDATA: shifts DATA_W bits per beat. On the accepted bit that completes a word, the memory is written at the current address and the address increments, wrapping modulo 2**ADDR_W. After the last beat the FSM goes to IDLE and rx_done pulses.
- WAIT: counts READ_LAT cycles, then goes to FETCH. Wait states occur before the first beat only.
- FETCH: drives the memory read address for one cycle. slave_valid = 0.
- RDATA: slave_valid = 1 and tx_data = dout[bit_cnt]. bit_cnt advances when master_ready = 1. When the last bit of a word is accepted:
  - if beats remain, the address increments (with wrap) and the FSM goes to FETCH
  - otherwise it goes to IDLE and tx_done pulses
- master_valid = 0 stalls ADDR/WDATA. master_ready = 0 stalls RDATA. Counters and data hold.
- read_en/write_en are ignored after the start cycle.

## Timing
- Reset values: state IDLE, slave_ready 1, slave_valid 0, tx_data 0, rx_done 0, tx_done 0, counters 0. Memory contents are not cleared.
- Reset asserted mid-transaction aborts it immediately:
  - a partially shifted write word is discarded
  - completed beats remain stored
  - no done pulse is issued
- Unstalled single write (12/8): address in cycles 0–11, data in 12–19. The memory is updated at the edge ending cycle 19. rx_done is high in cycle 20.
- Unstalled single read: address in cycles 0–11, WAIT in 12..11+READ_LAT, FETCH in 12+READ_LAT. The first data bit is valid in cycle 13+READ_LAT. tx_done is high the cycle after the final accepted bit.
- Between read beats there is exactly one FETCH cycle with slave_valid = 0.
- Burst wrap: address 2**ADDR_W−1 + 1 → 0.

## Structure
- Package bus_slave_pkg holds:
  - the state enum
  - localparams for counter widths ($clog2(ADDR_W), $clog2(DATA_W), BURST_W, 4-bit wait counter)
- Sub-module bus_slave_ram: single-port RAM with synchronous read, synchronous write and 1-cycle read latency, parametrised by ADDR_W and DATA_W. It infers block RAM and replaces the vendor IP wrapper.
- FSM, shift registers and counters live in bus_slave_mem.

## Test plan
- Write 0xA5 to address 0x123, then read it back (READ_LAT 0) -> tx_data bits 1,0,1,0,0,1,0,1 in cycles 13–20; rx_done and tx_done pulse once each.
- Burst write, field 3, at address 0xFFE, data 0x11, 0x22, 0x33, 0x44 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 hold those values; a burst read returns them in order with one slave_valid = 0 cycle between words.
- READ_LAT = 5, read address 0x010 -> slave_valid first rises in cycle 18.
- master_valid low for 3 cycles mid-data, then master_ready low for 2 cycles mid-read -> stored and returned words are unchanged; completion is delayed by exactly 3 and 2 cycles.
- read_en = write_en = 1 with master_valid = 1 -> FSM stays IDLE and no memory change.
- reset pulsed in cycle 15 of a write to address 0x020 -> outputs reach reset values immediately; 0x020 keeps its old value; a new transaction completes normally.
